// File: rtl/except_ctrl_pkg.sv
// Shared definitions for the MEM-stage exception controller:
// exception codes, CP0 addresses, handler vector, FSM states.
package except_ctrl_pkg;

  localparam logic [4:0] EXC_NONE = 5'h00;
  localparam logic [4:0] EXC_INT  = 5'h01;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_TR   = 5'h0d;
  localparam logic [4:0] EXC_ERET = 5'h0e;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  localparam int F_IADEL = 0;
  localparam int F_RI    = 1;
  localparam int F_OV    = 2;
  localparam int F_TRAP  = 3;
  localparam int F_SYS   = 4;
  localparam int F_BP    = 5;
  localparam int F_LADEL = 6;
  localparam int F_SADES = 7;
  localparam int F_ERET  = 8;

  // Last HOLD count value; HOLD lasts 15 cycles (0..14).
  localparam logic [3:0] HOLD_LAST = 4'd14;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } exc_state_e;

endpackage

// File: rtl/except_ctrl_prio.sv
// exc_prio: combinational priority encoder, flags + interrupt -> code.
// Ports: exc[8:0] flags, take_int, code[4:0].
module exc_prio
  import except_ctrl_pkg::*;
(
  input  logic [8:0] exc,
  input  logic       take_int,
  output logic [4:0] code
);

  always_comb begin
    code = EXC_NONE;
    priority case (1'b1)
      take_int:     code = EXC_INT;
      exc[F_IADEL]: code = EXC_ADEL;
      exc[F_RI]:    code = EXC_RI;
      exc[F_OV]:    code = EXC_OV;
      exc[F_TRAP]:  code = EXC_TR;
      exc[F_SYS]:   code = EXC_SYS;
      exc[F_BP]:    code = EXC_BP;
      exc[F_LADEL]: code = EXC_ADEL;
      exc[F_SADES]: code = EXC_ADES;
      exc[F_ERET]:  code = EXC_ERET;
      default:      code = EXC_NONE;
    endcase
  end

endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception controller: commits exceptions/interrupts to CP0,
// flushes the pipe and redirects fetch. Ports: clk, rst, stall, MEM
// instruction info, CP0 state + same-cycle MTC0, CP0 update, flush/new_pc.
module except_ctrl
  import except_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_pc_i,
  input  logic        mem_in_delayslot_i,
  input  logic [31:0] mem_bad_vaddr_i,
  input  logic [8:0]  mem_exc_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        mem_cp0_we_i,
  input  logic [4:0]  mem_cp0_waddr_i,
  input  logic [31:0] mem_cp0_wdata_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] pc_o,
  output logic [31:0] bad_vaddr_o,
  output logic        is_in_delayslot_o,
  output logic        flush_o,
  output logic [31:0] new_pc_o,
  output logic        int_pending_o
);

  exc_state_e  state, state_nxt;
  logic [3:0]  tmo_cnt;
  logic [31:0] npc_q;

  logic        wr_status, wr_cause, wr_epc;
  logic [7:0]  im, ip;
  logic        ie, exl;
  logic [31:0] epc_eff;
  logic        int_req, take_int;
  logic        in_run, commit;
  logic [4:0]  code;

  logic unused_bits;
  assign unused_bits = &{1'b0, stall[5], stall[3:0],
    cp0_status_i[31:16], cp0_status_i[7:2],
    cp0_cause_i[31:16], cp0_cause_i[7:0]};

  // MTC0 in MEM this cycle overrides the architectural CP0 view.
  assign wr_status = mem_cp0_we_i && (mem_cp0_waddr_i == CP0_STATUS);
  assign wr_cause  = mem_cp0_we_i && (mem_cp0_waddr_i == CP0_CAUSE);
  assign wr_epc    = mem_cp0_we_i && (mem_cp0_waddr_i == CP0_EPC);

  assign im  = wr_status ? mem_cp0_wdata_i[15:8] : cp0_status_i[15:8];
  assign ie  = wr_status ? mem_cp0_wdata_i[0] : cp0_status_i[0];
  assign exl = wr_status ? mem_cp0_wdata_i[1] : cp0_status_i[1];
  // Only the software interrupt bits of Cause are writable.
  assign ip  = {cp0_cause_i[15:10],
                wr_cause ? mem_cp0_wdata_i[9:8] : cp0_cause_i[9:8]};
  assign epc_eff = wr_epc ? mem_cp0_wdata_i : cp0_epc_i;

  assign int_req  = ie & ~exl & (|(ip & im));
  assign take_int = int_pending_o & int_req;

  assign in_run = (state == ST_RUN);
  assign commit = ~rst & mem_valid_i & ~stall[4] & in_run;

  exc_prio u_prio (
    .exc      (mem_exc_i),
    .take_int (take_int),
    .code     (code)
  );

  assign flush_o      = commit & (code != EXC_NONE);
  assign excepttype_o = commit ? {27'd0, code} : 32'd0;
  assign new_pc_o     = !flush_o ? 32'd0 :
                        (code == EXC_ERET) ? epc_eff : EXC_VECTOR;

  assign pc_o              = mem_pc_i;
  assign is_in_delayslot_o = mem_in_delayslot_i;

  // Fetch AdEL outranks load AdEL, so the flag tells them apart.
  always_comb begin
    bad_vaddr_o = 32'd0;
    if (commit && code == EXC_ADEL)
      bad_vaddr_o = mem_exc_i[F_IADEL] ? mem_pc_i : mem_bad_vaddr_i;
    else if (commit && code == EXC_ADES)
      bad_vaddr_o = mem_bad_vaddr_i;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:   if (flush_o) state_nxt = ST_DRAIN;
      ST_DRAIN: state_nxt = ST_HOLD;
      ST_HOLD:
        if ((mem_valid_i && mem_pc_i == npc_q) ||
            tmo_cnt == HOLD_LAST)
          state_nxt = ST_RUN;
      default:  state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_RUN;
      int_pending_o <= 1'b0;
      tmo_cnt       <= 4'd0;
      npc_q         <= 32'd0;
    end else begin
      state         <= state_nxt;
      int_pending_o <= in_run & int_req;
      if (state == ST_HOLD && state_nxt == ST_HOLD)
        tmo_cnt <= tmo_cnt + 4'd1;
      else
        tmo_cnt <= 4'd0;
      if (flush_o)
        npc_q <= new_pc_o;
    end
  end

endmodule

// File: tb/tb_except_ctrl.sv
// Self-checking bench for except_ctrl: vector table plus
// multi-cycle sequences, checked through an expectation queue.
module tb_except_ctrl;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk, rst;
  logic [5:0]  stall;
  logic        mem_valid_i, mem_in_delayslot_i;
  logic [31:0] mem_pc_i, mem_bad_vaddr_i;
  logic [8:0]  mem_exc_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
  logic        mem_cp0_we_i;
  logic [4:0]  mem_cp0_waddr_i;
  logic [31:0] mem_cp0_wdata_i;
  logic [31:0] excepttype_o, pc_o, bad_vaddr_o, new_pc_o;
  logic        is_in_delayslot_o, flush_o, int_pending_o;

  except_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall),
    .mem_valid_i(mem_valid_i), .mem_pc_i(mem_pc_i),
    .mem_in_delayslot_i(mem_in_delayslot_i),
    .mem_bad_vaddr_i(mem_bad_vaddr_i), .mem_exc_i(mem_exc_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
    .cp0_epc_i(cp0_epc_i), .mem_cp0_we_i(mem_cp0_we_i),
    .mem_cp0_waddr_i(mem_cp0_waddr_i),
    .mem_cp0_wdata_i(mem_cp0_wdata_i),
    .excepttype_o(excepttype_o), .pc_o(pc_o),
    .bad_vaddr_o(bad_vaddr_o),
    .is_in_delayslot_o(is_in_delayslot_o),
    .flush_o(flush_o), .new_pc_o(new_pc_o),
    .int_pending_o(int_pending_o)
  );

  typedef struct {
    logic        valid;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
    logic [8:0]  exc;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [5:0]  stall;
  } in_t;

  typedef struct {
    string       name;
    logic [31:0] et;
    logic        fl;
    logic [31:0] npc;
    logic [31:0] bv;
    logic        ip;
    logic [31:0] pc;
    logic        ds;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk_in(
    input logic v, input logic [8:0] exc,
    input logic [31:0] pc, input logic ds,
    input logic [31:0] bad, input logic [31:0] epc,
    input logic we, input logic [4:0] wa,
    input logic [31:0] wd, input logic [5:0] st);
    in_t r;
    r.valid = v; r.exc = exc; r.pc = pc; r.ds = ds;
    r.bad = bad; r.epc = epc; r.we = we; r.waddr = wa;
    r.wdata = wd; r.stall = st;
    r.status = 32'd0; r.cause = 32'd0;
    return r;
  endfunction

  function automatic exp_t mk_exp(
    input string nm, input logic [31:0] et, input logic fl,
    input logic [31:0] npc, input logic [31:0] bv,
    input logic ip);
    exp_t r;
    r.name = nm; r.et = et; r.fl = fl; r.npc = npc;
    r.bv = bv; r.ip = ip; r.pc = 32'd0; r.ds = 1'b0;
    return r;
  endfunction

  function automatic in_t simple(
    input logic [8:0] exc, input logic [31:0] pc);
    return mk_in(1'b1, exc, pc, 1'b0, 32'd0, 32'd0,
                 1'b0, 5'd0, 32'd0, 6'd0);
  endfunction

  task automatic apply(input in_t v);
    mem_valid_i = v.valid; mem_pc_i = v.pc;
    mem_in_delayslot_i = v.ds; mem_bad_vaddr_i = v.bad;
    mem_exc_i = v.exc; cp0_status_i = v.status;
    cp0_cause_i = v.cause; cp0_epc_i = v.epc;
    mem_cp0_we_i = v.we; mem_cp0_waddr_i = v.waddr;
    mem_cp0_wdata_i = v.wdata; stall = v.stall;
  endtask

  task automatic compare();
    exp_t e;
    e = sb.pop_front();
    checks++;
    if (excepttype_o !== e.et || flush_o !== e.fl ||
        new_pc_o !== e.npc || bad_vaddr_o !== e.bv ||
        int_pending_o !== e.ip || pc_o !== e.pc ||
        is_in_delayslot_o !== e.ds) begin
      errors++;
      $display("FAIL %s: got et=%h fl=%b npc=%h bv=%h ip=%b pc=%h ds=%b want et=%h fl=%b npc=%h bv=%h ip=%b pc=%h ds=%b",
        e.name, excepttype_o, flush_o, new_pc_o, bad_vaddr_o,
        int_pending_o, pc_o, is_in_delayslot_o,
        e.et, e.fl, e.npc, e.bv, e.ip, e.pc, e.ds);
    end
  endtask

  // Drive one cycle, queue its expectation, check before the edge.
  task automatic step(input in_t v, input exp_t e);
    apply(v);
    e.pc = v.pc;
    e.ds = v.ds;
    sb.push_back(e);
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    apply(simple(9'd0, 32'd0));
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic exp_t idle_e(input string nm, input logic ip);
    return mk_exp(nm, 32'd0, 1'b0, 32'd0, 32'd0, ip);
  endfunction

  vec_t tbl[$];
  in_t  v;

  initial begin
    rst = 1'b1;
    apply(simple(9'd0, 32'd0));
    @(posedge clk);
    #1;

    // Reset held with an exception present: nothing committed.
    step(simple(9'h004, 32'h8000_0004), idle_e("rst_hold", 1'b0));
    rst = 1'b0;

    tbl.push_back('{simple(9'h000, 32'h8000_0000),
      mk_exp("idle", 32'h0, 0, 32'h0, 32'h0, 0)});
    tbl.push_back('{mk_in(0, 9'h004, 32'h8000_0008, 0, 0, 0, 0, 0, 0, 0),
      mk_exp("novalid", 32'h0, 0, 32'h0, 32'h0, 0)});
    tbl.push_back('{mk_in(1, 9'h001, 32'h8000_0101, 0,
      32'h1234_5678, 0, 0, 0, 0, 0),
      mk_exp("iadel", 32'h4, 1, VEC, 32'h8000_0101, 0)});
    tbl.push_back('{simple(9'h002, 32'h8000_0104),
      mk_exp("ri", 32'ha, 1, VEC, 32'h0, 0)});
    tbl.push_back('{mk_in(1, 9'h014, 32'h8000_0010, 1, 0, 0, 0, 0, 0, 0),
      mk_exp("ov_sys", 32'hc, 1, VEC, 32'h0, 0)});
    tbl.push_back('{simple(9'h038, 32'h8000_0108),
      mk_exp("trap", 32'hd, 1, VEC, 32'h0, 0)});
    tbl.push_back('{simple(9'h030, 32'h8000_010c),
      mk_exp("sys_bp", 32'h8, 1, VEC, 32'h0, 0)});
    tbl.push_back('{simple(9'h020, 32'h8000_0110),
      mk_exp("bp", 32'h9, 1, VEC, 32'h0, 0)});
    tbl.push_back('{mk_in(1, 9'h0c0, 32'h8000_0114, 0,
      32'h8000_0003, 0, 0, 0, 0, 0),
      mk_exp("ladel", 32'h4, 1, VEC, 32'h8000_0003, 0)});
    tbl.push_back('{mk_in(1, 9'h080, 32'h8000_0118, 0,
      32'h0000_1001, 0, 0, 0, 0, 0),
      mk_exp("sades", 32'h5, 1, VEC, 32'h0000_1001, 0)});
    tbl.push_back('{mk_in(1, 9'h100, 32'h8000_011c, 0, 0,
      32'h8000_0020, 0, 0, 0, 0),
      mk_exp("eret", 32'he, 1, 32'h8000_0020, 32'h0, 0)});
    tbl.push_back('{mk_in(1, 9'h100, 32'h8000_0120, 0, 0,
      32'h8000_0020, 1, 5'd14, 32'h8000_0040, 0),
      mk_exp("eret_fwd", 32'he, 1, 32'h8000_0040, 32'h0, 0)});
    tbl.push_back('{mk_in(1, 9'h100, 32'h8000_0124, 0, 0,
      32'h8000_0020, 1, 5'd12, 32'h8000_0040, 0),
      mk_exp("eret_nofwd", 32'he, 1, 32'h8000_0020, 32'h0, 0)});
    tbl.push_back('{mk_in(1, 9'h041, 32'h8000_0200, 0,
      32'h0000_0005, 0, 0, 0, 0, 0),
      mk_exp("iadel_ladel", 32'h4, 1, VEC, 32'h8000_0200, 0)});
    tbl.push_back('{mk_in(1, 9'h180, 32'h8000_0204, 0,
      32'h0000_2002, 32'h8000_0020, 0, 0, 0, 0),
      mk_exp("eret_ades", 32'h5, 1, VEC, 32'h0000_2002, 0)});
    tbl.push_back('{mk_in(1, 9'h004, 32'h8000_0208, 0, 0, 0,
      0, 0, 0, 6'b101111),
      mk_exp("ov_stall_oth", 32'hc, 1, VEC, 32'h0, 0)});

    foreach (tbl[k]) begin
      do_reset();
      step(tbl[k].i, tbl[k].e);
    end

    // Interrupt via IP2 with IE and IM2 set.
    do_reset();
    v = simple(9'h000, 32'h8000_1000);
    v.status = 32'h0000_0401;
    v.cause  = 32'h0000_0400;
    step(v, idle_e("int_c1", 1'b0));
    step(v, mk_exp("int_c2", 32'h1, 1, VEC, 32'h0, 1));
    step(v, idle_e("int_drain", 1'b1));
    step(v, idle_e("int_hold", 1'b0));

    // Request withdrawn before it is taken.
    do_reset();
    step(v, idle_e("int_wd_c1", 1'b0));
    v.cause = 32'h0;
    step(v, idle_e("int_wd_c2", 1'b1));
    step(v, idle_e("int_wd_c3", 1'b0));

    // EXL masks interrupts.
    do_reset();
    v.status = 32'h0000_0403;
    v.cause  = 32'h0000_0400;
    step(v, idle_e("exl_c1", 1'b0));
    step(v, idle_e("exl_c2", 1'b0));

    // Software interrupt through a same-cycle Cause write.
    do_reset();
    v = mk_in(1, 9'h000, 32'h8000_1100, 0, 0, 0,
              1, 5'd13, 32'h0000_0100, 0);
    v.status = 32'h0000_0101;
    step(v, idle_e("swi_c1", 1'b0));
    step(v, mk_exp("swi_c2", 32'h1, 1, VEC, 32'h0, 1));

    // Cause write cannot set hardware IP bits.
    do_reset();
    v = mk_in(1, 9'h000, 32'h8000_1200, 0, 0, 0,
              1, 5'd13, 32'h0000_0400, 0);
    v.status = 32'h0000_0401;
    step(v, idle_e("hwip_c1", 1'b0));
    step(v, idle_e("hwip_c2", 1'b0));

    // Status write enabling an already-raised IP2.
    do_reset();
    v = mk_in(1, 9'h000, 32'h8000_1300, 0, 0, 0,
              1, 5'd12, 32'h0000_0401, 0);
    v.cause = 32'h0000_0400;
    step(v, idle_e("stfwd_c1", 1'b0));
    step(v, mk_exp("stfwd_c2", 32'h1, 1, VEC, 32'h0, 1));

    // Load AdEL held by a MEM stall for three cycles.
    do_reset();
    v = mk_in(1, 9'h040, 32'h8000_0400, 0, 32'h8000_0003,
              0, 0, 0, 0, 6'h10);
    for (int c = 0; c < 3; c++)
      step(v, idle_e("stall_hold", 1'b0));
    v.stall = 6'h00;
    step(v, mk_exp("stall_rel", 32'h4, 1, VEC, 32'h8000_0003, 0));
    step(v, idle_e("stall_once", 1'b0));

    // DRAIN and HOLD ignore exceptions until the handler PC returns.
    do_reset();
    step(simple(9'h004, 32'h8000_0300),
         mk_exp("dh_take", 32'hc, 1, VEC, 32'h0, 0));
    step(simple(9'h004, 32'h8000_0304), idle_e("dh_drain", 1'b0));
    step(simple(9'h004, 32'h8000_0308), idle_e("dh_hold", 1'b0));
    v = simple(9'h004, VEC);
    v.valid = 1'b0;
    step(v, idle_e("dh_novalid", 1'b0));
    step(simple(9'h004, 32'h8000_030c), idle_e("dh_hold2", 1'b0));
    step(simple(9'h000, VEC), idle_e("dh_match", 1'b0));
    step(simple(9'h004, 32'hBFC0_0384),
         mk_exp("dh_retake", 32'hc, 1, VEC, 32'h0, 0));

    // Reset while in HOLD.
    step(simple(9'h004, 32'h8000_0600), idle_e("rh_drain", 1'b0));
    rst = 1'b1;
    step(simple(9'h004, 32'h8000_0604), idle_e("rh_rst", 1'b0));
    rst = 1'b0;
    step(simple(9'h004, 32'h8000_0608),
         mk_exp("rh_after", 32'hc, 1, VEC, 32'h0, 0));

    // HOLD timeout: DRAIN + 15 HOLD cycles, then RUN.
    do_reset();
    step(simple(9'h004, 32'h8000_0500),
         mk_exp("to_take", 32'hc, 1, VEC, 32'h0, 0));
    for (int c = 0; c < 16; c++)
      step(simple(9'h004, 32'h8000_0504), idle_e("to_wait", 1'b0));
    step(simple(9'h004, 32'h8000_0504),
         mk_exp("to_expire", 32'hc, 1, VEC, 32'h0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
